// File: rtl/matriz_writer.sv
// Pixel writer for a 5 x 7 LED matrix: set/clear/toggle single pixels,
// sweep-based clear-all, and a blinking cursor overlay on the outputs.
module matriz_writer #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_x,
  input  logic [2:0] cmd_y,
  input  logic       cursor_en,
  input  logic [2:0] cursor_x,
  input  logic [2:0] cursor_y,
  output logic [6:0] col1,
  output logic [6:0] col2,
  output logic [6:0] col3,
  output logic [6:0] col4,
  output logic [6:0] col5,
  output logic       busy,
  output logic       err
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_nxt;
  logic [2:0]       sweep;
  logic [6:0]       mem [5];
  logic [6:0]       disp [5];
  logic             acc, is_clr, pix_ok;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_ph;
  logic             cur_en_p0;
  logic [2:0]       cur_x_p0, cur_y_p0;

  assign acc    = cmd_valid & cmd_ready;
  assign is_clr = (cmd_op == 2'b11);
  assign pix_ok = (cmd_x <= 3'd4) && (cmd_y <= 3'd6);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: clear-all enters CLEAR, last sweep column returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc && is_clr) state_nxt = CLEAR;
      CLEAR:   if (sweep == 3'd4) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: commands are refused while sweeping or held in reset
  always_comb begin
    cmd_ready = (state == IDLE) && !rst;
    busy      = (state == CLEAR);
  end

  // Sweep index walks columns 0..4 while in CLEAR, rests at 0 otherwise
  always_ff @(posedge clk) begin
    if (rst)                                  sweep <= 3'd0;
    else if (state == CLEAR && sweep != 3'd4) sweep <= sweep + 3'd1;
    else                                      sweep <= 3'd0;
  end

  // Pixel storage: sweep zeroing or single-bit update on an accepted command
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 5; c++) mem[c] <= 7'd0;
    end else if (state == CLEAR) begin
      mem[sweep] <= 7'd0;
    end else if (acc && !is_clr && pix_ok) begin
      case (cmd_op)
        2'b00:   mem[cmd_x][cmd_y] <= 1'b1;
        2'b01:   mem[cmd_x][cmd_y] <= 1'b0;
        default: mem[cmd_x][cmd_y] <= ~mem[cmd_x][cmd_y];
      endcase
    end
  end

  // Error pulse for an accepted pixel command aimed outside the matrix
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= acc && !is_clr && !pix_ok;
  end

  // Blink half-period counter; phase flips on every wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == CNT_MAX) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // ---- stage p0: cursor controls registered so outputs depend on state only
  // Cursor enable register
  always_ff @(posedge clk) begin
    if (rst) cur_en_p0 <= 1'b0;
    else     cur_en_p0 <= cursor_en;
  end

  // Cursor position register
  always_ff @(posedge clk) begin
    cur_x_p0 <= cursor_x;
    cur_y_p0 <= cursor_y;
  end

  // Display: stored columns with the cursor pixel inverted during blink phase 1
  always_comb begin
    for (int c = 0; c < 5; c++) begin
      disp[c] = mem[c];
      if (cur_en_p0 && blink_ph && (cur_x_p0 <= 3'd4) && (cur_y_p0 <= 3'd6) &&
          (cur_x_p0 == 3'(c)))
        disp[c] = mem[c] ^ (7'd1 << cur_y_p0);
    end
  end

  assign col1 = disp[0];
  assign col2 = disp[1];
  assign col3 = disp[2];
  assign col4 = disp[3];
  assign col5 = disp[4];

endmodule
